// File: rtl/bcd_countdown_2digit_pkg.sv
// ---------------------------------------------------------------------------
// bcd_countdown_2digit_pkg
// Shared definitions for the two-digit BCD countdown timer: controller state
// encoding, the largest legal BCD digit and a digit clamp helper.
// ---------------------------------------------------------------------------
package bcd_countdown_2digit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Values 10..15 are not BCD; saturate them to the largest digit.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        logic [3:0] r;
        if (d > BCD_MAX) begin
            r = BCD_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_countdown_2digit_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit_down
// One BCD digit that counts down and wraps 0 -> 9.
// Ports:
//   clock     system clock
//   reset     synchronous active-high reset, clears the digit
//   dec       decrement request (ignored while load is high)
//   load      load strobe, takes priority over dec
//   load_val  value to load (caller guarantees 0..9)
//   digit     current digit value
//   borrow    dec while digit is 0; decrements the next-higher digit
//   is_zero   digit equals 0
// ---------------------------------------------------------------------------
module bcd_digit_down
    import bcd_countdown_2digit_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow,
    output logic       is_zero
);

    logic [3:0] digit_r;

    // Digit register: reset, then load, then decrement with 0 -> 9 wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_r <= 4'd0;
        end else if (load) begin
            digit_r <= load_val;
        end else if (dec) begin
            if (digit_r == 4'd0) begin
                digit_r <= BCD_MAX;
            end else begin
                digit_r <= digit_r - 4'd1;
            end
        end else begin
            digit_r <= digit_r;
        end
    end

    assign digit   = digit_r;
    assign is_zero = (digit_r == 4'd0);
    assign borrow  = dec && (digit_r == 4'd0);

endmodule

// File: rtl/bcd_countdown_2digit.sv
// ---------------------------------------------------------------------------
// bcd_countdown_2digit
// Loadable two-digit BCD countdown timer with run/pause/done control and a
// built-in tick prescaler (TICK_DIV clock cycles per count step).
// Ports:
//   clock      system clock
//   reset      synchronous active-high reset
//   load       strobe: capture clamped load_dig1/load_dig0, go IDLE
//   load_dig1  tens digit to load
//   load_dig0  ones digit to load
//   start      strobe: start from IDLE (value non-zero) or resume from PAUSE
//   stop       strobe: pause from RUN
//   dig1       tens digit, BCD
//   dig0       ones digit, BCD
//   running    high while in RUN (registered)
//   done       one-cycle pulse on entry to DONE (registered)
// ---------------------------------------------------------------------------
module bcd_countdown_2digit
    import bcd_countdown_2digit_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_dig1,
    input  logic [3:0] load_dig0,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_e        state_r, state_next_s;
    logic [PW-1:0] presc_r, presc_next_s;
    logic          running_r, done_r;
    logic          running_next_s, done_next_s;

    logic          tick_s, dec_s, dec_to_zero_s, value_zero_s;
    logic          ones_borrow_s, ones_zero_s, tens_zero_s;
    logic          unused_tens_borrow_s;

    // A step is due on the last prescaler count in RUN; stop and load pre-empt it.
    assign tick_s        = (state_r == ST_RUN) && (presc_r == TICK_LAST);
    assign dec_s         = tick_s && !stop && !load;
    assign value_zero_s  = tens_zero_s && ones_zero_s;
    // Only 01 decrements into 00; that edge also enters DONE.
    assign dec_to_zero_s = dec_s && tens_zero_s && (dig0 == 4'd1);

    bcd_digit_down u_ones (
        .clock    (clock),
        .reset    (reset),
        .dec      (dec_s),
        .load     (load),
        .load_val (clamp_bcd(load_dig0)),
        .digit    (dig0),
        .borrow   (ones_borrow_s),
        .is_zero  (ones_zero_s)
    );

    bcd_digit_down u_tens (
        .clock    (clock),
        .reset    (reset),
        .dec      (ones_borrow_s),
        .load     (load),
        .load_val (clamp_bcd(load_dig1)),
        .digit    (dig1),
        .borrow   (unused_tens_borrow_s),
        .is_zero  (tens_zero_s)
    );

    // State, prescaler and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            presc_r   <= {PW{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            presc_r   <= presc_next_s;
            running_r <= running_next_s;
            done_r    <= done_next_s;
        end
    end

    // Next-state and next-prescaler logic; load overrides everything.
    always_comb begin
        state_next_s = state_r;
        presc_next_s = presc_r;
        if (load) begin
            state_next_s = ST_IDLE;
            presc_next_s = {PW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !value_zero_s) begin
                        state_next_s = ST_RUN;
                        presc_next_s = {PW{1'b0}};
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Prescaler is held so resume continues mid-step.
                        state_next_s = ST_PAUSE;
                    end else if (tick_s) begin
                        presc_next_s = {PW{1'b0}};
                        if (dec_to_zero_s) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_RUN;
                        end
                    end else begin
                        presc_next_s = presc_r + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    presc_next_s = {PW{1'b0}};
                end
            endcase
        end
    end

    // Status outputs derived from the upcoming state so they register with it.
    always_comb begin
        running_next_s = (state_next_s == ST_RUN);
        done_next_s    = (state_next_s == ST_DONE) && (state_r != ST_DONE);
    end

    assign running = running_r;
    assign done    = done_r;

endmodule
